// File: rtl/verilog_counter_checker_pkg.sv
// Shared definitions for the counter-stream checker: state encoding and default parameters.
package verilog_counter_checker_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        SYNC    = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH        = 129;
    localparam int unsigned DEF_LOCK_COUNT   = 4;
    localparam int unsigned DEF_UNLOCK_COUNT = 2;
    localparam int unsigned DEF_CNT_WIDTH    = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async reset, sync clear and increment enable.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Holds at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/verilog_counter_checker.sv
// Checks that a sampled counter stream increments by exactly one per valid sample;
// tracks lock, flags mismatches while locked and keeps saturating error/match counts.
module verilog_counter_checker
    import verilog_counter_checker_pkg::*;
#(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned LOCK_COUNT   = DEF_LOCK_COUNT,
    parameter int unsigned UNLOCK_COUNT = DEF_UNLOCK_COUNT,
    parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] good_count
);

    localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W = $clog2(UNLOCK_COUNT + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   ref_q, ref_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               err_inc, good_inc;
    logic               match;
    logic [RUN_W-1:0]   run_inc;
    logic [MISS_W-1:0]  miss_inc;

    // Expected successor wraps naturally at WIDTH bits
    assign match    = (in_data == (ref_q + WIDTH'(1)));
    assign run_inc  = run_q + RUN_W'(1);
    assign miss_inc = miss_q + MISS_W'(1);

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        run_d       = run_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        good_inc    = 1'b0;

        if (clear) begin
            state_d = ACQUIRE;
            ref_d   = '0;
            run_d   = '0;
            miss_d  = '0;
        end else if (in_valid) begin
            ref_d = in_data;
            case (state_q)
                ACQUIRE: begin
                    run_d   = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (match) begin
                        run_d = run_inc;
                        if (run_inc == RUN_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_d   = '0;
                        good_inc = 1'b1;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        miss_d      = miss_inc;
                        if (miss_inc == MISS_W'(UNLOCK_COUNT)) begin
                            state_d = SYNC;
                            run_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                    run_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACQUIRE;
            ref_q       <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_err_count (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (err_inc),
        .count (err_count)
    );

    sat_counter #(.W(CNT_WIDTH)) u_good_count (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (good_inc),
        .count (good_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_verilog_counter_checker.sv
// Scoreboard bench: a behavioural model pushes expected outputs per driven cycle; they are
// popped and compared after the edge against a 32-bit-counter DUT and a 4-bit-counter DUT.
module tb_verilog_counter_checker;

    localparam int unsigned W   = 129;
    localparam int unsigned LCK = 4;
    localparam int unsigned UNL = 2;

    typedef struct {
        logic        locked;
        logic        pulse;
        logic [31:0] err32;
        logic [31:0] good32;
        logic [3:0]  err4;
        logic [3:0]  good4;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic [W-1:0]  in_data;

    logic          locked_a, pulse_a, locked_b, pulse_b;
    logic [31:0]   errc_a, goodc_a;
    logic [3:0]    errc_b, goodc_b;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            pulses_seen;

    int            m_state, m_run, m_miss, m_err, m_good;
    logic [W-1:0]  m_ref;
    logic          m_pulse;
    logic [W-1:0]  all_ones;

    always #5 clk = ~clk;

    verilog_counter_checker #(.WIDTH(W), .LOCK_COUNT(LCK), .UNLOCK_COUNT(UNL), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(locked_a), .err_pulse(pulse_a), .err_count(errc_a), .good_count(goodc_a)
    );

    verilog_counter_checker #(.WIDTH(W), .LOCK_COUNT(LCK), .UNLOCK_COUNT(UNL), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(locked_b), .err_pulse(pulse_b), .err_count(errc_b), .good_count(goodc_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_miss = 0; m_err = 0; m_good = 0;
        m_ref = '0; m_pulse = 1'b0;
    endtask

    // Behavioural model of one clock edge; pushes the outputs expected after it
    task automatic model_step(input logic v, input logic [W-1:0] d, input logic c);
        exp_t e;
        logic mt;
        m_pulse = 1'b0;
        mt = (d == (m_ref + W'(1)));
        if (c) begin
            model_reset();
        end else if (v) begin
            case (m_state)
                0: begin m_ref = d; m_run = 0; m_state = 1; end
                1: begin
                    m_ref = d;
                    if (mt) begin
                        m_run++;
                        if (m_run == LCK) begin m_state = 2; m_miss = 0; end
                    end else m_run = 0;
                end
                default: begin
                    m_ref = d;
                    if (mt) begin m_miss = 0; m_good++; end
                    else begin
                        m_pulse = 1'b1; m_err++; m_miss++;
                        if (m_miss == UNL) begin m_state = 1; m_run = 0; end
                    end
                end
            endcase
        end
        e.locked = (m_state == 2);
        e.pulse  = m_pulse;
        e.err32  = 32'(m_err);
        e.good32 = 32'(m_good);
        e.err4   = (m_err  > 15) ? 4'd15 : 4'(m_err);
        e.good4  = (m_good > 15) ? 4'd15 : 4'(m_good);
        sb_q.push_back(e);
    endtask

    task automatic compare_all(input exp_t e);
        check("locked_a", 64'(locked_a), 64'(e.locked));
        check("pulse_a",  64'(pulse_a),  64'(e.pulse));
        check("err_a",    64'(errc_a),   64'(e.err32));
        check("good_a",   64'(goodc_a),  64'(e.good32));
        check("locked_b", 64'(locked_b), 64'(e.locked));
        check("pulse_b",  64'(pulse_b),  64'(e.pulse));
        check("err_b",    64'(errc_b),   64'(e.err4));
        check("good_b",   64'(goodc_b),  64'(e.good4));
    endtask

    // Called at posedge+1; drives one cycle, then pops and compares after the edge
    task automatic step(input logic v, input logic [W-1:0] d, input logic c);
        exp_t e;
        in_valid = v; in_data = d; clear = c;
        model_step(v, d, c);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'(1), 64'(0));
        end else begin
            e = sb_q.pop_front();
            compare_all(e);
        end
        if (pulse_a) pulses_seen++;
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic feed_run(input logic [W-1:0] start, input int n);
        logic [W-1:0] d;
        d = start;
        for (int i = 0; i < n; i++) begin
            step(1'b1, d, 1'b0);
            d = d + W'(1);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"}, 64'({locked_a, locked_b}), 64'(0));
        check({tag, "_pulse"},  64'({pulse_a, pulse_b}),   64'(0));
        check({tag, "_err"},    64'({errc_a, errc_b}),     64'(0));
        check({tag, "_good"},   64'({goodc_a, goodc_b}),   64'(0));
    endtask

    initial begin
        exp_t z;
        all_ones = '1;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst_rel");

        // 1: clean stream locks after four matches
        feed_run(W'(0), 5);
        check("t1_locked", 64'(locked_a), 64'(1));
        check("t1_err", 64'(errc_a), 64'(0));

        // 2: wrap through all-ones -> 0 is a match
        step(1'b0, '0, 1'b1);
        feed_run(all_ones - W'(6), 5);
        pulses_seen = 0;
        feed_run(all_ones - W'(1), 4);
        check("t2_pulses", 64'(pulses_seen), 64'(0));
        check("t2_good", 64'(goodc_a), 64'(4));
        check("t2_locked", 64'(locked_a), 64'(1));

        // 3: single glitch while locked
        step(1'b0, '0, 1'b1);
        feed_run(W'(6), 5);
        pulses_seen = 0;
        step(1'b1, W'(11), 1'b0);
        step(1'b1, W'(13), 1'b0);
        check("t3_pulse_after13", 64'(pulse_a), 64'(1));
        step(1'b1, W'(14), 1'b0);
        check("t3_pulses", 64'(pulses_seen), 64'(1));
        check("t3_err", 64'(errc_a), 64'(1));
        check("t3_locked", 64'(locked_a), 64'(1));

        // 4: two consecutive mismatches drop lock, then relock
        step(1'b0, '0, 1'b1);
        feed_run(W'(16), 5);
        step(1'b1, W'(50), 1'b0);
        step(1'b1, W'(70), 1'b0);
        check("t4_unlock", 64'(locked_a), 64'(0));
        check("t4_pulse_on_unlock", 64'(pulse_a), 64'(1));
        check("t4_err", 64'(errc_a), 64'(2));
        feed_run(W'(71), 4);
        check("t4_relock", 64'(locked_a), 64'(1));

        // 5: gapped stream, clear with valid, async reset mid-stream
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, W'(i), 1'b0);
            step(1'b0, W'(99), 1'b0);
            step(1'b0, W'(99), 1'b0);
        end
        check("t5_gap_locked", 64'(locked_a), 64'(1));
        step(1'b1, W'(6), 1'b1);
        check_zero("t5_clear");
        feed_run(W'(0), 3);
        #2;
        reset = 1'b1;
        #1;
        check_zero("t5_async");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero("t5_post_rst");

        // 6: 20 isolated mismatches saturate the 4-bit counter
        step(1'b0, '0, 1'b1);
        feed_run(W'(0), 5);
        pulses_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, m_ref + W'(2), 1'b0);
            step(1'b1, m_ref + W'(1), 1'b0);
        end
        check("t6_pulses", 64'(pulses_seen), 64'(20));
        check("t6_err_a", 64'(errc_a), 64'(20));
        check("t6_err_b", 64'(errc_b), 64'(15));
        check("t6_locked_b", 64'(locked_b), 64'(1));
        check("t6_sb_drained", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
